// File: rtl/camac_tag_master_pkg.sv
// camac_tag_master_pkg: shared FSM encoding, timing defaults and counter widths for the tag master
package camac_tag_master_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        HOLD    = 3'd3,
        WAITBSY = 3'd4
    } state_t;
    localparam int SETUP_CYC = 5;
    localparam int PULSE_CYC = 10;
    localparam int HOLD_CYC  = 10;
    localparam int ENC_W     = 14;
    localparam int SNC_W     = 10;
endpackage

// File: rtl/camac_tag_master_if.sv
// camac_tag_master_if: rear-panel tag link bundle between the master and the readout cards
interface camac_tag_master_if #(
    parameter int ENC_W = camac_tag_master_pkg::ENC_W,
    parameter int SNC_W = camac_tag_master_pkg::SNC_W
);
    logic             TRIGIN;
    logic             SPILLIN;
    logic             VETO;
    logic             LOCKIN;
    logic             BSYIN;
    logic [ENC_W-1:0] ENC;
    logic [SNC_W-1:0] SNC;
    logic             TRIG1;
    logic             TRIG2;
    logic             LOCK;
    logic             BSYOUT;
    logic [15:0]      NACC;
    modport master (
        input  TRIGIN, SPILLIN, VETO, LOCKIN, BSYIN,
        output ENC, SNC, TRIG1, TRIG2, LOCK, BSYOUT, NACC
    );
    modport slave (
        output TRIGIN, SPILLIN, VETO, LOCKIN, BSYIN,
        input  ENC, SNC, TRIG1, TRIG2, LOCK, BSYOUT, NACC
    );
endinterface

// File: rtl/camac_tag_master_edge_sync.sv
// tag_edge_sync: 3-flop synchroniser for an asynchronous NIM level with a single-cycle rising-edge flag
module tag_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise
);
    logic [2:0] s;
    // two metastability stages, one output register; the edge flag lines up with lvl going high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            rise <= 1'b0;
        end else begin
            s    <= {s[1:0], d};
            rise <= s[1] & ~s[2];
        end
    end
    assign lvl = s[2];
endmodule

// File: rtl/camac_tag_master.sv
// camac_tag_master: tag link master - accepts triggers, counts events/spills, strobes a stable tag word
module camac_tag_master #(
    parameter int SETUP_CYC = camac_tag_master_pkg::SETUP_CYC,
    parameter int PULSE_CYC = camac_tag_master_pkg::PULSE_CYC,
    parameter int HOLD_CYC  = camac_tag_master_pkg::HOLD_CYC,
    parameter int ENC_W     = camac_tag_master_pkg::ENC_W,
    parameter int SNC_W     = camac_tag_master_pkg::SNC_W
) (
    input logic                SYSCLK,
    input logic                RST,
    camac_tag_master_if.master bus
);
    import camac_tag_master_pkg::*;
    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n, t1cnt, t1cnt_n;
    logic [ENC_W-1:0] enc, enc_n;
    logic [SNC_W-1:0] snc, snc_n;
    logic [15:0]      nacc, nacc_n;
    logic             t1, t1_n, t2, t2_n, bsy, bsy_n, pend, pend_n, lock;
    logic             trg_e, spl_e, veto_s, bsy_s;
    logic             trg_lvl_unused, spl_lvl_unused, veto_rise_unused, bsy_rise_unused;

    tag_edge_sync u_trg  (.clk(SYSCLK), .rst(RST), .d(bus.TRIGIN),  .lvl(trg_lvl_unused), .rise(trg_e));
    tag_edge_sync u_spl  (.clk(SYSCLK), .rst(RST), .d(bus.SPILLIN), .lvl(spl_lvl_unused), .rise(spl_e));
    tag_edge_sync u_veto (.clk(SYSCLK), .rst(RST), .d(bus.VETO),    .lvl(veto_s), .rise(veto_rise_unused));
    tag_edge_sync u_bsy  (.clk(SYSCLK), .rst(RST), .d(bus.BSYIN),   .lvl(bsy_s),  .rise(bsy_rise_unused));

    // state and all tag outputs; reset drops strobes and busy at once
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            t1cnt <= '0;
            enc   <= '0;
            snc   <= '0;
            nacc  <= '0;
            t1    <= 1'b0;
            t2    <= 1'b0;
            bsy   <= 1'b0;
            pend  <= 1'b0;
            lock  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            t1cnt <= t1cnt_n;
            enc   <= enc_n;
            snc   <= snc_n;
            nacc  <= nacc_n;
            t1    <= t1_n;
            t2    <= t2_n;
            bsy   <= bsy_n;
            pend  <= pend_n;
            lock  <= bus.LOCKIN;
        end
    end

    // counters move only in IDLE so ENC/SNC stay frozen across the whole TRIG2 window
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 8'd1;
        enc_n   = enc;
        snc_n   = snc;
        nacc_n  = nacc;
        pend_n  = pend | spl_e;
        t2_n    = t2;
        bsy_n   = bsy;
        t1_n    = t1 && (t1cnt != 8'(PULSE_CYC - 1));
        t1cnt_n = t1 ? t1cnt + 8'd1 : 8'd0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pend || spl_e) begin
                    snc_n  = snc + 1'b1;
                    enc_n  = '0;
                    nacc_n = '0;
                    pend_n = 1'b0;
                end else if (trg_e && !veto_s && !bsy_s) begin
                    enc_n   = enc + 1'b1;
                    nacc_n  = nacc + {15'd0, ~&nacc};
                    bsy_n   = 1'b1;
                    t1_n    = 1'b1;
                    t1cnt_n = '0;
                    state_n = SETUP;
                end
            end
            SETUP: if (cnt == 8'(SETUP_CYC - 1)) begin
                t2_n    = 1'b1;
                cnt_n   = '0;
                state_n = PULSE;
            end
            PULSE: if (cnt == 8'(PULSE_CYC - 1)) begin
                t2_n    = 1'b0;
                cnt_n   = '0;
                state_n = HOLD;
            end
            HOLD: if (cnt == 8'(HOLD_CYC - 1)) begin
                cnt_n   = '0;
                state_n = WAITBSY;
            end
            WAITBSY: if (!bsy_s) begin
                bsy_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ENC    = enc;
    assign bus.SNC    = snc;
    assign bus.NACC   = nacc;
    assign bus.TRIG1  = t1;
    assign bus.TRIG2  = t2;
    assign bus.BSYOUT = bsy;
    assign bus.LOCK   = lock;
endmodule

// File: tb/tb_camac_tag_master.sv
// tb_camac_tag_master: vector table plus hand sequences, with a TRIG2-driven tag scoreboard
module tb_camac_tag_master;
    import camac_tag_master_pkg::*;
    typedef struct {
        int kind;
        bit veto;
        bit bsy;
        int enc;
        int snc;
        int nacc;
    } vec_t;
    logic SYSCLK, RST;
    int n_chk, n_fail, n_t1;
    int w1, w2, d12, hc;
    logic p1, p2;
    logic [SNC_W+ENC_W-1:0] tag;
    logic [SNC_W+ENC_W-1:0] sbq[$];
    vec_t vt[9];

    camac_tag_master_if bus ();
    camac_tag_master_if #(.ENC_W(3), .SNC_W(2)) bus2 ();
    camac_tag_master dut (.SYSCLK(SYSCLK), .RST(RST), .bus(bus.master));
    camac_tag_master #(.ENC_W(3), .SNC_W(2)) dut_s (.SYSCLK(SYSCLK), .RST(RST), .bus(bus2.master));

    assign bus2.TRIGIN  = bus.TRIGIN;
    assign bus2.SPILLIN = bus.SPILLIN;
    assign bus2.VETO    = bus.VETO;
    assign bus2.LOCKIN  = bus.LOCKIN;
    assign bus2.BSYIN   = bus.BSYIN;

    initial SYSCLK = 1'b0;
    always #10 SYSCLK = ~SYSCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic pulse_trg();
        bus.TRIGIN = 1'b1;
        tick(5);
        bus.TRIGIN = 1'b0;
    endtask

    task automatic pulse_spl();
        bus.SPILLIN = 1'b1;
        tick(5);
        bus.SPILLIN = 1'b0;
    endtask

    task automatic wait_t2();
        int k = 0;
        while (!bus.TRIG2 && k < 60) begin
            tick(1);
            k++;
        end
        chk("trig2_seen", bus.TRIG2, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.BSYOUT && k < 200) begin
            tick(1);
            k++;
        end
        chk("bsyout_released", bus.BSYOUT, 0);
    endtask

    // pulse widths, TRIG1->TRIG2 setup, tag at TRIG2 rise and tag stability through the hold window
    always @(negedge SYSCLK) begin
        if (RST) begin
            p1 = 0; p2 = 0; w1 = 0; w2 = 0; d12 = 0; hc = 0;
        end else begin
            d12++;
            if (bus.TRIG1) w1++;
            if (bus.TRIG2) w2++;
            if (bus.TRIG1 && !p1) begin
                d12 = 0;
                n_t1++;
            end
            if (!bus.TRIG1 && p1) begin
                chk("trig1_width", w1, PULSE_CYC);
                w1 = 0;
            end
            if (p2 || hc > 0) chk("tag_stable", {bus.SNC, bus.ENC}, tag);
            if (hc > 0 && !bus.TRIG2) hc--;
            if (bus.TRIG2 && !p2) begin
                chk("trig1_to_trig2", d12, SETUP_CYC);
                chk("trig2_expected", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) chk("tag_at_trig2", {bus.SNC, bus.ENC}, sbq.pop_front());
                tag = {bus.SNC, bus.ENC};
            end
            if (!bus.TRIG2 && p2) begin
                chk("trig2_width", w2, PULSE_CYC);
                w2 = 0;
                hc = HOLD_CYC;
            end
            p1 = bus.TRIG1;
            p2 = bus.TRIG2;
        end
    end

    initial begin
        int n, b;
        n_chk = 0; n_fail = 0; n_t1 = 0;
        // kind: 0 trigger, 1 spill, 2 spill and trigger rising together
        vt[0] = '{1, 0, 0, 0, 1, 0};
        vt[1] = '{0, 0, 0, 1, 1, 1};
        vt[2] = '{0, 0, 0, 2, 1, 2};
        vt[3] = '{0, 0, 0, 3, 1, 3};
        vt[4] = '{0, 1, 0, 3, 1, 3};
        vt[5] = '{0, 0, 1, 3, 1, 3};
        vt[6] = '{0, 0, 0, 4, 1, 4};
        vt[7] = '{2, 0, 0, 0, 2, 0};
        vt[8] = '{0, 0, 0, 1, 2, 1};
        bus.TRIGIN = 0; bus.SPILLIN = 0; bus.VETO = 0; bus.BSYIN = 0; bus.LOCKIN = 1;
        RST = 1;
        tick(3);
        chk("rst_enc", bus.ENC, 0);
        chk("rst_snc", bus.SNC, 0);
        chk("rst_nacc", bus.NACC, 0);
        chk("rst_trig1", bus.TRIG1, 0);
        chk("rst_trig2", bus.TRIG2, 0);
        chk("rst_bsyout", bus.BSYOUT, 0);
        chk("rst_lock", bus.LOCK, 0);
        RST = 0;
        tick(1);
        chk("lock_high", bus.LOCK, 1);
        bus.LOCKIN = 0;
        tick(1);
        chk("lock_low", bus.LOCK, 0);
        tick(3);
        // first trigger: exact busy release after the hold window
        sbq.push_back({SNC_W'(0), ENC_W'(1)});
        pulse_trg();
        wait_t2();
        n = 0;
        while (bus.TRIG2 && n < 30) begin tick(1); n++; end
        n = 0;
        while (bus.BSYOUT && n < 40) begin tick(1); n++; end
        chk("bsyout_fall_cycles", n, HOLD_CYC + 1);
        tick(2);
        chk("first_enc", bus.ENC, 1);
        chk("first_nacc", bus.NACC, 1);
        for (int i = 0; i < 9; i++) begin
            bus.VETO = vt[i].veto;
            bus.BSYIN = vt[i].bsy;
            tick(4);
            b = n_t1;
            if (vt[i].kind == 0 && !vt[i].veto && !vt[i].bsy) sbq.push_back({SNC_W'(vt[i].snc), ENC_W'(vt[i].enc)});
            bus.TRIGIN = vt[i].kind != 1;
            bus.SPILLIN = vt[i].kind != 0;
            tick(5);
            bus.TRIGIN = 0;
            bus.SPILLIN = 0;
            tick(4);
            bus.VETO = 0;
            bus.BSYIN = 0;
            tick(40);
            chk("row_enc", bus.ENC, vt[i].enc);
            chk("row_snc", bus.SNC, vt[i].snc);
            chk("row_nacc", bus.NACC, vt[i].nacc);
            chk("row_bsyout", bus.BSYOUT, 0);
            chk("row_trig1_count", n_t1 - b, int'(vt[i].kind == 0 && !vt[i].veto && !vt[i].bsy));
            chk("row_small_enc", bus2.ENC, vt[i].enc % 8);
            chk("row_small_snc", bus2.SNC, vt[i].snc % 4);
        end
        // receivers busy for 2 us after TRIG2; a second trigger inside that time is dropped
        sbq.push_back({SNC_W'(2), ENC_W'(2)});
        pulse_trg();
        wait_t2();
        bus.BSYIN = 1;
        tick(20);
        pulse_trg();
        tick(75);
        chk("bsy_hold_bsyout", bus.BSYOUT, 1);
        chk("bsy_hold_enc", bus.ENC, 2);
        bus.BSYIN = 0;
        tick(3);
        chk("bsy_sync_latency", bus.BSYOUT, 1);
        tick(1);
        chk("bsy_release", bus.BSYOUT, 0);
        tick(40);
        chk("bsy_enc", bus.ENC, 2);
        chk("bsy_nacc", bus.NACC, 2);
        // two spill edges while busy: applied once, only after returning to IDLE
        sbq.push_back({SNC_W'(2), ENC_W'(3)});
        pulse_trg();
        wait_t2();
        pulse_spl();
        tick(5);
        pulse_spl();
        tick(2);
        chk("spill_busy_snc", bus.SNC, 2);
        chk("spill_busy_enc", bus.ENC, 3);
        wait_idle();
        tick(2);
        chk("spill_idle_snc", bus.SNC, 3);
        chk("spill_idle_enc", bus.ENC, 0);
        chk("spill_idle_nacc", bus.NACC, 0);
        tick(40);
        chk("spill_once_snc", bus.SNC, 3);
        // wrap-around on the narrow instance: SNC 3->0, ENC 7->0
        pulse_spl();
        tick(20);
        chk("wrap_small_snc", bus2.SNC, 0);
        chk("wrap_snc", bus.SNC, 4);
        for (int i = 1; i <= 9; i++) begin
            sbq.push_back({SNC_W'(4), ENC_W'(i)});
            pulse_trg();
            tick(40);
            chk("wrap_enc", bus.ENC, i);
            chk("wrap_small_enc", bus2.ENC, i % 8);
            chk("wrap_nacc", bus.NACC, i);
        end
        // reset in the middle of the TRIG2 pulse
        sbq.push_back({SNC_W'(4), ENC_W'(10)});
        pulse_trg();
        wait_t2();
        tick(2);
        #4 RST = 1;
        #1;
        chk("midrst_trig2", bus.TRIG2, 0);
        chk("midrst_bsyout", bus.BSYOUT, 0);
        chk("midrst_enc", bus.ENC, 0);
        chk("midrst_snc", bus.SNC, 0);
        tick(3);
        RST = 0;
        tick(3);
        sbq.push_back({SNC_W'(0), ENC_W'(1)});
        pulse_trg();
        tick(40);
        chk("postrst_enc", bus.ENC, 1);
        chk("postrst_nacc", bus.NACC, 1);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/camac_tag_master.md
Name: camac_tag_master

Overview:
- Master end of the rear-panel RJ45 tag link. Drives ENC, SNC, TRIG1, TRIG2 and LOCK into the readout-module CAMAC cards, and takes back their OR-ed busy.
- Counts accepted triggers (event number) and spill starts (spill number).
- Presents the tag word stable before, during and after the TRIG2 strobe, so receivers that latch on the TRIG2 rising edge get a clean value.
- Gates new triggers while the receivers or the master itself are busy.

Parameters:
- SETUP_CYC, 5, SYSCLK cycles ENC/SNC are stable before the TRIG2 rising edge (100 ns at 50 MHz).
- PULSE_CYC, 10, TRIG1/TRIG2 high width in cycles.
- HOLD_CYC, 10, cycles ENC/SNC stay stable after TRIG2 falls.
- ENC_W, 14, event counter width.
- SNC_W, 10, spill counter width.

Ports:
- SYSCLK  in  1  system clock, 50 MHz
- RST  in  1  reset, asynchronous, active-high
- TRIGIN  in  1  NIM trigger request, asynchronous, rising edge active
- SPILLIN  in  1  NIM spill-start, asynchronous, rising edge active
- VETO  in  1  asynchronous trigger inhibit (level)
- LOCKIN  in  1  run-lock level, passed to LOCK
- BSYIN  in  1  OR-ed receiver busy (their BSYOUT), asynchronous
- ENC  out  ENC_W  event number counter
- SNC  out  SNC_W  spill number counter
- TRIG1  out  1  prompt accept pulse
- TRIG2  out  1  tag strobe
- LOCK  out  1  registered LOCKIN
- BSYOUT  out  1  master busy
- NACC  out  16  accepted-trigger count since last spill start, saturating

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; spill-pending flag clear.
- Input synchronisation:
  - TRIGIN, SPILLIN, VETO, BSYIN each pass through the 3-flop synchroniser (2 sync stages plus 1 output register).
  - TRIGIN and SPILLIN are then rising-edge detected, giving single-cycle trg_e and spl_e.
  - LOCK = LOCKIN delayed by 1 register.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAITBSY.
- IDLE:
  - If spill-pending or spl_e: SNC <= SNC+1 (wraps 2^SNC_W-1 -> 0); ENC <= 0; NACC <= 0; clear pending. Stay in IDLE. A trg_e in that same cycle is dropped.
  - Else if trg_e and synced VETO=0 and synced BSYIN=0:
    - ENC <= ENC+1 (wraps 16383 -> 0); NACC <= NACC+1, saturating at 65535.
    - BSYOUT <= 1; TRIG1 <= 1; counter <= 0; go to SETUP.
  - trg_e while VETO or BSYIN is high is dropped; no counter change.
- SETUP: after SETUP_CYC cycles, TRIG2 <= 1 and go to PULSE.
  - First event after reset/spill: ENC=1.
  - With edge at cycle E: ENC valid and TRIG1 rises at E+1; TRIG2 rises at E+1+SETUP_CYC.
- TRIG1: high exactly PULSE_CYC cycles from E+1, independent of state.
- PULSE: TRIG2 high exactly PULSE_CYC cycles, then low; go to HOLD.
- HOLD: HOLD_CYC cycles, then WAITBSY.
- WAITBSY: stay while synced BSYIN=1; when it is 0, BSYOUT <= 0 and go to IDLE the next cycle.
- Tag stability: ENC/SNC change only in IDLE.
- Spill edge outside IDLE: sets spill-pending, which is applied in the IDLE cycle entered. Multiple spill edges while busy count once.
- Trigger edges while not in IDLE are ignored and never queued.
- RST mid-cycle: TRIG1/TRIG2/BSYOUT drop immediately (async); counters return to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=0 .. WAITBSY=4); default timing constants SETUP_CYC/PULSE_CYC/HOLD_CYC; ENC_W/SNC_W.
- One sub-module, tag_edge_sync: 3-flop synchroniser with async reset, sync level output plus single-cycle rising-edge output. Instantiated four times; edge output unused for VETO/BSYIN.

Test Plan:
- Reset, then TRIGIN pulse 100 ns, BSYIN=0:
  - ENC=1 from E+1; TRIG1 high 10 cycles; TRIG2 high cycles E+6..E+15.
  - BSYOUT falls after HOLD plus 1 cycle; NACC=1.
- Spill then 3 triggers:
  - SNC=1; ENC steps 1,2,3; ENC never changes while TRIG2=1 or within 10 cycles after it falls.
- BSYIN held high 2 us after the first TRIG2, second TRIGIN during that time:
  - Second trigger dropped; ENC stays 1; BSYOUT held until BSYIN low plus sync latency.
- VETO high, TRIGIN pulse:
  - No TRIG1/TRIG2; ENC and NACC unchanged.
- SPILLIN rising during PULSE:
  - SNC unchanged until IDLE, then +1 and ENC=0. Same-cycle trigger edge dropped.
- Preset ENC=16383 via 16383 triggers (or forced), one more trigger:
  - ENC=0.
- RST asserted during PULSE:
  - TRIG2, BSYOUT, ENC=0 within the same cycle; after release, next trigger gives ENC=1.
